// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
package regfile_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned ZERO_REG       = 0;

  // Clear engine / availability state
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared on writeback, flushed on reset or array clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_RD_PORTS = 2
) (
  input  logic                               clk,
  input  logic                               flush,
  input  logic                               set_en,
  input  logic [ADDR_WIDTH-1:0]              set_idx,
  input  logic                               clr_en,
  input  logic [ADDR_WIDTH-1:0]              clr_idx,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] look_idx,
  output logic [NUM_RD_PORTS-1:0]            look_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  // Next busy vector: clear first so a same-cycle issue to the same register wins
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    if (set_en) busy_nxt[set_idx] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
  end

  // Busy bit register with synchronous flush
  always_ff @(posedge clk) begin
    if (flush) busy <= '0;
    else       busy <= busy_nxt;
  end

  // Raw per-port lookups; bypass and ready masking are applied by the caller
  always_comb begin
    look_busy = '0;
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      look_busy[p] = busy[look_idx[p*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with writeback bypass, pending-write
// scoreboard and a sequential clear engine. Register 0 reads as zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned BYPASS       = 1
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               CLR_REQ,
  output logic                               READY,
  input  logic                               WEN,
  input  logic [ADDR_WIDTH-1:0]              RD_SEL,
  input  logic [DATA_WIDTH-1:0]              WB_DATA,
  input  logic                               ISSUE_EN,
  input  logic [ADDR_WIDTH-1:0]              ISSUE_RD,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] RS_SEL,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] SRC_DOUT,
  output logic [NUM_RD_PORTS-1:0]            RS_BUSY
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_ok;
  logic                    wen_eff;
  logic                    issue_eff;
  logic                    sb_flush;
  logic [NUM_RD_PORTS-1:0] sb_busy;

  // Writeback/issue only act in READY, out of reset, and not in a clear-request cycle
  assign wr_ok     = ready & RESET & ~CLR_REQ;
  assign wen_eff   = wr_ok & WEN;
  assign issue_eff = wr_ok & ISSUE_EN & (ISSUE_RD != ZERO_IDX);
  assign sb_flush  = ~RESET | (ready & CLR_REQ);

  // State register and clear counter
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      else                   clr_cnt <= '0;
    end
  end

  // Next-state logic: leave CLEAR after the last index, re-enter on request
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_CLEAR: if (clr_cnt == '1) state_nxt = ST_READY;
      ST_READY: if (CLR_REQ)       state_nxt = ST_CLEAR;
      default:                     state_nxt = ST_CLEAR;
    endcase
  end

  // State outputs
  always_comb begin
    ready = (state == ST_READY);
  end

  assign READY = ready;

  // Array write port: clear engine zeroes one entry per cycle, otherwise writeback
  always_ff @(posedge CLK) begin
    if (RESET && state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wen_eff && RD_SEL != ZERO_IDX) begin
      mem[RD_SEL] <= WB_DATA;
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .NUM_RD_PORTS (NUM_RD_PORTS)
  ) u_scoreboard (
    .clk       (CLK),
    .flush     (sb_flush),
    .set_en    (issue_eff),
    .set_idx   (ISSUE_RD),
    .clr_en    (wen_eff),
    .clr_idx   (RD_SEL),
    .look_idx  (RS_SEL),
    .look_busy (sb_busy)
  );

  // Read ports: zero register and not-ready force 0; same-cycle writeback forwards
  always_comb begin
    logic [ADDR_WIDTH-1:0] rs;
    logic                  hit;
    SRC_DOUT = '0;
    RS_BUSY  = '0;
    rs       = '0;
    hit      = 1'b0;
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      rs  = RS_SEL[p*ADDR_WIDTH +: ADDR_WIDTH];
      hit = (BYPASS != 0) && WEN && (RD_SEL == rs);
      if (ready && rs != ZERO_IDX) begin
        SRC_DOUT[p*DATA_WIDTH +: DATA_WIDTH] = hit ? WB_DATA : mem[rs];
        RS_BUSY[p]                           = hit ? 1'b0 : sb_busy[p];
      end
    end
  end

endmodule
